cache_miss_ctrl: RTL and testbench

//  Sequences miss handling for the 2-way data cache: writes back the dirty victim, refills the missing word from main memory,
//  and returns it to the cache over the wnextin/old_address/datamemin fill port. Sits between the cache and the main-memory port.

---
 rtl/cache_ctrl_pkg.sv | 24 ++
 rtl/mem_wait_timer.sv | 44 ++++
 rtl/cache_miss_ctrl.sv | 167 ++++++++++++++++
 tb/tb_cache_miss_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_ctrl_pkg
// Description : Shared definitions for the data-cache miss controller.
//               Holds the miss-sequencer state encoding, the wait-timer width
//               and the default memory timeout.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_ctrl_pkg;

    // Miss sequencer states: idle, victim writeback, refill read, fill strobe.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        RF   = 2'd2,
        FILL = 2'd3
    } state_t;

    // Width of the per-transfer wait counter (bounds TIMEOUT to 1..255).
    localparam int unsigned c_TMR_W           = 8;
    localparam int unsigned c_TIMEOUT_DEFAULT = 255;

endpackage : cache_ctrl_pkg
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : mem_wait_timer
// Description : Counts cycles spent waiting for a memory acknowledge and
//               flags the cycle in which the wait reaches TIMEOUT cycles.
// Ports       : clk       - clock
//               reset     - asynchronous active-low reset
//               i_clear   - zero the count (has priority over i_enable)
//               i_enable  - count one more waiting cycle
//               o_expired - this is the TIMEOUT-th waiting cycle
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wait_timer
    import cache_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = c_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    // Count of waiting cycles already completed; expiry is flagged one count
    // early so the controller can abort at the end of the TIMEOUT-th cycle.
    localparam logic [c_TMR_W-1:0] c_LAST = c_TMR_W'(TIMEOUT - 1);

    logic [c_TMR_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + c_TMR_W'(1);
        end
    end

    assign o_expired = (r_count == c_LAST);

endmodule : mem_wait_timer
`default_nettype wire

// File: rtl/cache_miss_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cache_miss_ctrl
// Description : Miss sequencer for the 2-way data cache. Writes back a dirty
//               victim, refills the missing word from main memory and hands
//               it to the cache through the fill port. Holds the pipeline for
//               the whole miss, keeps saturating miss/writeback counters and
//               raises a sticky error on memory timeout.
// Ports       : clk, reset (async active-low)
//               cache side : miss, miss_is_write, memwr, miss_addr,
//                            victim_addr, victim_data -> wnextin,
//                            old_address, datamemin, stall
//               memory side: mem_req, mem_we, mem_addr, mem_wdata <- mem_ack,
//                            mem_rdata
//               status     : err, miss_cnt, wb_cnt
// Revision    : 1.0 - initial release
// ============================================================================
module cache_miss_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = c_TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             miss,
    input  logic             miss_is_write,
    input  logic             memwr,
    input  logic [AW-1:0]    miss_addr,
    input  logic [AW-1:0]    victim_addr,
    input  logic [DW-1:0]    victim_data,
    output logic             wnextin,
    output logic [AW-1:0]    old_address,
    output logic [DW-1:0]    datamemin,
    output logic             stall,
    output logic             mem_req,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_wdata,
    input  logic             mem_ack,
    input  logic [DW-1:0]    mem_rdata,
    output logic             err,
    output logic [CNT_W-1:0] miss_cnt,
    output logic [CNT_W-1:0] wb_cnt
);

    state_t        r_state;
    logic [AW-1:0] r_miss_addr;
    logic          r_is_write;

    logic w_busy;
    logic w_tmr_clear;
    logic w_expired;
    logic w_timeout;

    // A memory transfer is outstanding only in WB and RF.
    assign w_busy      = (r_state == WB) || (r_state == RF);
    // Holding the timer at zero outside a transfer and on every ack means it
    // always starts from zero on entry to WB or RF (including WB->RF).
    assign w_tmr_clear = !w_busy || mem_ack;
    assign w_timeout   = w_busy && !mem_ack && w_expired;

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_tmr_clear),
        .i_enable  (w_busy),
        .o_expired (w_expired)
    );

    // The victim address/data are captured straight into mem_addr/mem_wdata,
    // which stay put until the writeback is acknowledged, so they double as
    // the victim latch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_miss_addr <= '0;
            r_is_write  <= 1'b0;
            wnextin     <= 1'b0;
            old_address <= '0;
            datamemin   <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            err         <= 1'b0;
            miss_cnt    <= '0;
            wb_cnt      <= '0;
        end else begin
            wnextin <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (miss) begin
                        r_miss_addr <= miss_addr;
                        r_is_write  <= miss_is_write;
                        if (miss_cnt != '1) begin
                            miss_cnt <= miss_cnt + CNT_W'(1);
                        end
                        if (memwr) begin
                            r_state   <= WB;
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_addr  <= victim_addr;
                            mem_wdata <= victim_data;
                        end else if (!miss_is_write) begin
                            r_state  <= RF;
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= miss_addr;
                        end
                        // A clean store miss needs no memory traffic.
                    end
                end
                WB: begin
                    if (mem_ack) begin
                        if (wb_cnt != '1) begin
                            wb_cnt <= wb_cnt + CNT_W'(1);
                        end
                        if (!r_is_write) begin
                            // Switch straight to the refill read; mem_req
                            // stays high with no idle cycle in between.
                            r_state  <= RF;
                            mem_we   <= 1'b0;
                            mem_addr <= r_miss_addr;
                        end else begin
                            r_state <= IDLE;
                            mem_req <= 1'b0;
                        end
                    end else if (w_timeout) begin
                        r_state <= IDLE;
                        mem_req <= 1'b0;
                        err     <= 1'b1;
                    end
                end
                RF: begin
                    if (mem_ack) begin
                        r_state     <= FILL;
                        mem_req     <= 1'b0;
                        wnextin     <= 1'b1;
                        old_address <= r_miss_addr;
                        datamemin   <= mem_rdata;
                    end else if (w_timeout) begin
                        r_state <= IDLE;
                        mem_req <= 1'b0;
                        err     <= 1'b1;
                    end
                end
                FILL: begin
                    // Any miss seen here is ignored; the cache re-presents it.
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Combinational so the pipeline holds in the very cycle the miss appears.
    assign stall = reset && (miss || (r_state != IDLE));

endmodule : cache_miss_ctrl
`default_nettype wire

// File: tb/tb_cache_miss_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_miss_ctrl
// Description : Self-checking bench for cache_miss_ctrl. A transaction-level
//               model (queue of pending memory transfers plus a fill flag)
//               predicts every output each cycle; directed scenarios add
//               hand-computed expectations, then randomized traffic runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_miss_ctrl;

    localparam int unsigned AW      = 32;
    localparam int unsigned DW      = 32;
    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned CNT_W   = 2;
    localparam int          MAXC    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             miss, miss_is_write, memwr;
    logic [AW-1:0]    miss_addr, victim_addr;
    logic [DW-1:0]    victim_data;
    logic             wnextin;
    logic [AW-1:0]    old_address;
    logic [DW-1:0]    datamemin;
    logic             stall;
    logic             mem_req, mem_we;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_wdata;
    logic             mem_ack;
    logic [DW-1:0]    mem_rdata;
    logic             err;
    logic [CNT_W-1:0] miss_cnt, wb_cnt;

    cache_miss_ctrl #(
        .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .miss(miss), .miss_is_write(miss_is_write),
        .memwr(memwr), .miss_addr(miss_addr), .victim_addr(victim_addr),
        .victim_data(victim_data), .wnextin(wnextin), .old_address(old_address),
        .datamemin(datamemin), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .err(err), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: pending memory transfers in a queue, head = current.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } xfer_t;

    xfer_t         xq[$];
    bit            m_fill;
    logic [AW-1:0] m_fill_addr;
    logic [DW-1:0] m_fill_data;
    int            m_wait;
    bit            m_err;
    int            m_miss;
    int            m_wb;

    function automatic int sat_inc(input int v);
        return (v >= MAXC) ? MAXC : v + 1;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            xq.delete();
            m_fill = 0; m_wait = 0; m_err = 0; m_miss = 0; m_wb = 0;
        end else if (m_fill) begin
            m_fill = 0;
        end else if (xq.size() > 0) begin
            if (mem_ack) begin
                xfer_t t;
                t = xq.pop_front();
                m_wait = 0;
                if (t.we) begin
                    m_wb = sat_inc(m_wb);
                end else begin
                    m_fill = 1; m_fill_addr = t.addr; m_fill_data = mem_rdata;
                end
            end else begin
                m_wait++;
                if (m_wait == TIMEOUT) begin
                    m_err = 1; xq.delete(); m_wait = 0;
                end
            end
        end else if (miss) begin
            m_miss = sat_inc(m_miss);
            m_wait = 0;
            if (memwr) xq.push_back('{1'b1, victim_addr, victim_data});
            if (!miss_is_write) xq.push_back('{1'b0, miss_addr, '0});
        end
    end

    // Per-cycle comparison, mid low phase after inputs have been driven.
    always @(negedge clk) begin
        #2;
        if (reset) begin
            chk("stall", stall, miss || (xq.size() > 0) || m_fill);
            chk("mem_req", mem_req, xq.size() > 0);
            if (xq.size() > 0) begin
                chk("mem_we", mem_we, xq[0].we);
                chk("mem_addr", mem_addr, xq[0].addr);
                if (xq[0].we) chk("mem_wdata", mem_wdata, xq[0].data);
            end
            chk("wnextin", wnextin, m_fill);
            if (m_fill) begin
                chk("old_address", old_address, m_fill_addr);
                chk("datamemin", datamemin, m_fill_data);
            end
            chk("err", err, m_err);
            chk("miss_cnt", miss_cnt, m_miss);
            chk("wb_cnt", wb_cnt, m_wb);
        end else begin
            chk("rst_outs", {stall, mem_req, wnextin, err, miss_cnt, wb_cnt}, '0);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers and per-scenario observation counters
    // ------------------------------------------------------------------
    int            st_cnt, rq_cnt, fl_cnt;
    logic [AW-1:0] fl_addr, wr_addr;
    logic [DW-1:0] fl_data, wr_data;

    task automatic clr_obs();
        st_cnt = 0; rq_cnt = 0; fl_cnt = 0;
        fl_addr = '0; fl_data = '0; wr_addr = '0; wr_data = '0;
    endtask

    task automatic step(input logic m, input logic wr, input logic isw,
                        input logic [AW-1:0] ma, input logic [AW-1:0] va,
                        input logic [DW-1:0] vd, input logic ack,
                        input logic [DW-1:0] rd);
        @(negedge clk);
        miss = m; memwr = wr; miss_is_write = isw; miss_addr = ma;
        victim_addr = va; victim_data = vd; mem_ack = ack; mem_rdata = rd;
        #3;
        if (stall) st_cnt++;
        if (wnextin) begin fl_cnt++; fl_addr = old_address; fl_data = datamemin; end
        if (mem_req) begin
            rq_cnt++;
            if (mem_we) begin wr_addr = mem_addr; wr_data = mem_wdata; end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, '0, 0, '0);
    endtask

    initial begin
        reset = 1'b0; miss = 0; memwr = 0; miss_is_write = 0; miss_addr = '0;
        victim_addr = '0; victim_data = '0; mem_ack = 0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_req", mem_req, 1'b0);
        chk("reset_cnt", {miss_cnt, wb_cnt, err, wnextin}, '0);
        @(negedge clk);
        reset = 1'b1;

        // 1: clean load miss, ack on 3rd RF cycle
        clr_obs();
        step(1, 0, 0, 32'h40, '0, '0, 0, '0);
        step(0, 0, 0, '0, '0, '0, 0, '0);
        step(0, 0, 0, '0, '0, '0, 0, '0);
        step(0, 0, 0, '0, '0, '0, 1, 32'hDEADBEEF);
        idle(2);
        chk("t1_stall_w", st_cnt, 5);
        chk("t1_fills", fl_cnt, 1);
        chk("t1_fill_addr", fl_addr, 32'h40);
        chk("t1_fill_data", fl_data, 32'hDEADBEEF);
        chk("t1_miss_cnt", miss_cnt, 1);

        // 2: dirty load miss, writeback then refill with no req gap
        clr_obs();
        step(1, 1, 0, 32'h40, 32'h80, 32'h12345678, 0, '0);
        step(0, 0, 0, '0, '0, '0, 0, '0);
        step(0, 0, 0, '0, '0, '0, 1, '0);
        step(0, 0, 0, '0, '0, '0, 0, '0);
        step(0, 0, 0, '0, '0, '0, 1, 32'hCAFEF00D);
        idle(2);
        chk("t2_req_cycles", rq_cnt, 4);
        chk("t2_wr_addr", wr_addr, 32'h80);
        chk("t2_wr_data", wr_data, 32'h12345678);
        chk("t2_fill_data", fl_data, 32'hCAFEF00D);
        chk("t2_wb_cnt", wb_cnt, 1);
        chk("t2_miss_cnt", miss_cnt, 2);

        // 3: dirty store miss -> writeback only
        clr_obs();
        step(1, 1, 1, 32'h104, 32'h100, 32'h0000A5A5, 0, '0);
        step(0, 0, 0, '0, '0, '0, 1, '0);
        idle(2);
        chk("t3_req_cycles", rq_cnt, 1);
        chk("t3_fills", fl_cnt, 0);
        chk("t3_wb_cnt", wb_cnt, 2);

        // 3/6: clean store misses: 1-cycle stall, no memory, counter saturates
        clr_obs();
        step(1, 0, 1, 32'h44, '0, '0, 0, '0);
        idle(1);
        step(1, 0, 1, 32'h48, '0, '0, 0, '0);
        idle(1);
        chk("t3_clean_stall", st_cnt, 2);
        chk("t3_clean_req", rq_cnt, 0);
        chk("t6_miss_sat", miss_cnt, 3);

        // 6: miss during WB ignored; ack in IDLE ignored
        clr_obs();
        step(1, 1, 1, 32'h504, 32'h600, 32'h66, 0, '0);
        step(1, 0, 0, 32'h700, '0, '0, 0, '0);
        step(0, 0, 0, '0, '0, '0, 1, '0);
        idle(2);
        step(0, 0, 0, '0, '0, '0, 1, 32'h77);
        step(0, 0, 0, '0, '0, '0, 1, 32'h77);
        chk("t6_req_cycles", rq_cnt, 2);
        chk("t6_fills", fl_cnt, 0);
        chk("t6_wb_cnt", wb_cnt, 3);

        // 4: timeout with no ack, then a normal miss still serviced
        clr_obs();
        step(1, 0, 0, 32'h200, '0, '0, 0, '0);
        idle(5);
        chk("t4_req_cycles", rq_cnt, 4);
        chk("t4_stall_w", st_cnt, 5);
        chk("t4_err", err, 1'b1);
        chk("t4_stall_end", stall, 1'b0);
        chk("t4_fills", fl_cnt, 0);
        clr_obs();
        step(1, 0, 0, 32'h300, '0, '0, 0, '0);
        step(0, 0, 0, '0, '0, '0, 1, 32'h11);
        idle(2);
        chk("t4_fill_data", fl_data, 32'h11);
        chk("t4_err_sticky", err, 1'b1);

        // 5: async reset mid-RF, ack after release ignored
        clr_obs();
        step(1, 0, 0, 32'h400, '0, '0, 0, '0);
        step(0, 0, 0, '0, '0, '0, 0, '0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t5_req", mem_req, 1'b0);
        chk("t5_stall", stall, 1'b0);
        chk("t5_err", err, 1'b0);
        chk("t5_cnts", {miss_cnt, wb_cnt}, '0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        clr_obs();
        step(0, 0, 0, '0, '0, '0, 1, 32'h99);
        idle(2);
        chk("t5_fills", fl_cnt, 0);
        chk("t5_req_after", rq_cnt, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(99) < 30, $urandom_range(1), $urandom_range(99) < 30,
                 $urandom, $urandom, $urandom, $urandom_range(99) < 45, $urandom);
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_cache_miss_ctrl
`default_nettype wire
